// File: rtl/data_cache_ctrl.sv
// Direct-mapped, 16-line, one-word-per-line write-through / no-write-allocate
// data cache controller with a single-outstanding-transaction memory port.
module data_cache_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cache_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, WDONE} state_t;

  state_t      state;
  logic [15:0] valid;
  logic [25:0] tag_mem  [16];
  logic [31:0] data_mem [16];

  logic [3:0]  cpu_idx;
  logic [25:0] cpu_tag;
  logic [3:0]  mem_idx;
  logic [25:0] mem_tag;
  logic        cpu_hit;
  logic        mem_hit;
  logic        fill;
  logic        wr_update;

  assign cpu_idx = cpu_addr[5:2];
  assign cpu_tag = cpu_addr[31:6];
  assign mem_idx = mem_addr[5:2];
  assign mem_tag = mem_addr[31:6];

  assign cpu_hit = valid[cpu_idx] && (tag_mem[cpu_idx] == cpu_tag);
  // The latched address decides whether a store updates the line.
  assign mem_hit = valid[mem_idx] && (tag_mem[mem_idx] == mem_tag);

  assign fill      = (state == FETCH) && mem_ready;
  assign wr_update = (state == WRITE) && mem_ready && mem_hit;

  assign cpu_rdata = data_mem[cpu_idx];

  // NOTE: default assigned first so every path drives cache_stall; no latch.
  always_comb begin
    cache_stall = 1'b0;
    case (state)
      IDLE:          cache_stall = cpu_write | (cpu_read & ~cpu_hit);
      FETCH, WRITE:  cache_stall = 1'b1;
      WDONE:         cache_stall = 1'b0;
      default:       cache_stall = 1'b0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      valid     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_write) begin
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            state     <= WRITE;
          end else if (cpu_read && !cpu_hit) begin
            mem_addr <= cpu_addr;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (mem_ready) begin
            valid[mem_idx] <= 1'b1;
            mem_req        <= 1'b0;
            state          <= IDLE;
          end
        end
        WRITE: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= WDONE;
          end
        end
        WDONE:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: tag/data arrays carry no reset; the valid bits alone qualify them.
  // Reset forces state to IDLE, so an abandoned transaction never writes here.
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_mem[mem_idx]  <= mem_tag;
      data_mem[mem_idx] <= mem_rdata;
    end else if (wr_update) begin
      data_mem[mem_idx] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_data_cache_ctrl.sv
// Self-checking bench for data_cache_ctrl: directed scenarios followed by random
// traffic, checked against a line-level cache model and a word-level memory model.
module tb_data_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cache_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  data_cache_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cpu_read    (cpu_read),
    .cpu_write   (cpu_write),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cache_stall (cache_stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    logic [31:0] addr;
    logic [31:0] data;
  } line_t;

  line_t       model [16];
  logic [31:0] mem_model [logic [31:0]];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) model[i].valid = 1'b0;
  endtask

  function automatic logic [31:0] mem_value(input logic [31:0] addr);
    if (!mem_model.exists(addr)) mem_model[addr] = $urandom;
    return mem_model[addr];
  endfunction

  task automatic do_idle();
    @(negedge clk);
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    check("idle_stall", 32'(cache_stall), 32'd0);
    check("idle_mem_req", 32'(mem_req), 32'd0);
  endtask

  task automatic do_read(input logic [31:0] addr, input int lat);
    int          idx;
    bit          hit;
    logic [31:0] val;
    int          stalls;
    @(negedge clk);
    cpu_read  = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = addr;
    cpu_wdata = $urandom;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    idx = int'(addr[5:2]);
    hit = model[idx].valid && (model[idx].addr == addr);
    val = mem_value(addr);
    if (hit) begin
      check("hit_stall", 32'(cache_stall), 32'd0);
      check("hit_rdata", cpu_rdata, val);
      check("hit_mem_req", 32'(mem_req), 32'd0);
    end else begin
      check("miss_stall", 32'(cache_stall), 32'd1);
      stalls = int'(cache_stall);
      for (int c = 0; c < lat; c++) begin
        @(negedge clk);
        #1;
        stalls += int'(cache_stall);
        check("fetch_req", 32'(mem_req), 32'd1);
        check("fetch_we", 32'(mem_we), 32'd0);
        check("fetch_addr", mem_addr, addr);
        if (c == lat - 1) begin
          cpu_read  = 1'b1;
          cpu_write = 1'b0;
          cpu_addr  = addr;
          mem_ready = 1'b1;
          mem_rdata = val;
        end else begin
          cpu_addr  = $urandom;
          cpu_write = 1'($urandom_range(0, 1));
          cpu_wdata = $urandom;
          mem_ready = 1'b0;
        end
      end
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      #1;
      check("miss_stall_cycles", 32'(stalls), 32'(lat + 1));
      check("refill_stall", 32'(cache_stall), 32'd0);
      check("refill_rdata", cpu_rdata, val);
      check("refill_req_drop", 32'(mem_req), 32'd0);
      model[idx] = '{valid: 1'b1, addr: addr, data: val};
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int lat);
    int idx;
    @(negedge clk);
    cpu_write = 1'b1;
    cpu_read  = 1'($urandom_range(0, 1));
    cpu_addr  = addr;
    cpu_wdata = data;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    check("write_stall", 32'(cache_stall), 32'd1);
    for (int c = 0; c < lat; c++) begin
      @(negedge clk);
      #1;
      check("write_stall_hold", 32'(cache_stall), 32'd1);
      check("write_req", 32'(mem_req), 32'd1);
      check("write_we", 32'(mem_we), 32'd1);
      check("write_addr", mem_addr, addr);
      check("write_wdata", mem_wdata, data);
      cpu_addr  = $urandom;
      cpu_wdata = $urandom;
      cpu_read  = 1'($urandom_range(0, 1));
      mem_ready = (c == lat - 1);
    end
    // completion cycle: random CPU request must be ignored
    @(negedge clk);
    mem_ready = 1'b0;
    cpu_read  = 1'b1;
    cpu_write = 1'($urandom_range(0, 1));
    cpu_addr  = $urandom;
    #1;
    check("wdone_stall", 32'(cache_stall), 32'd0);
    check("wdone_req", 32'(mem_req), 32'd0);
    idx = int'(addr[5:2]);
    mem_model[addr] = data;
    if (model[idx].valid && model[idx].addr == addr) model[idx].data = data;
  endtask

  task automatic reset_mid_fetch(input logic [31:0] addr);
    @(negedge clk);
    cpu_read  = 1'b1;
    cpu_write = 1'b0;
    cpu_addr  = addr;
    mem_ready = 1'b0;
    @(negedge clk);
    #1;
    check("rst_fetch_req_before", 32'(mem_req), 32'd1);
    cpu_read = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("rst_fetch_req", 32'(mem_req), 32'd0);
    check("rst_fetch_we", 32'(mem_we), 32'd0);
    check("rst_fetch_addr", mem_addr, 32'd0);
    check("rst_fetch_stall", 32'(cache_stall), 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          op;
    rst_n     = 1'b0;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    model_reset();
    #2;
    check("reset_stall", 32'(cache_stall), 32'd0);
    check("reset_mem_req", 32'(mem_req), 32'd0);
    check("reset_mem_we", 32'(mem_we), 32'd0);
    check("reset_mem_addr", mem_addr, 32'd0);
    check("reset_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_idle();

    // cold read, hit, write hit, conflict, write miss
    mem_model[32'h0000_0040] = 32'hDEAD_BEEF;
    do_read(32'h0000_0040, 3);
    do_read(32'h0000_0040, 3);
    check("hit_data_const", cpu_rdata, 32'hDEAD_BEEF);
    do_write(32'h0000_0040, 32'h1234_5678, 2);
    do_read(32'h0000_0040, 2);
    check("write_hit_data_const", cpu_rdata, 32'h1234_5678);
    do_read(32'h0000_0080, 2);
    do_read(32'h0000_0040, 1);
    do_write(32'h0000_0100, 32'hCAFE_F00D, 3);
    do_read(32'h0000_0100, 2);
    check("write_miss_readback", cpu_rdata, 32'hCAFE_F00D);

    // reset during a fetch abandons it
    reset_mid_fetch(32'h0000_0080);
    do_idle();
    do_read(32'h0000_0080, 2);

    // random traffic over a small address pool to force hits and conflicts
    for (int i = 0; i < 300; i++) begin
      a  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      op = $urandom_range(0, 9);
      if (op < 5)      do_read(a, $urandom_range(1, 4));
      else if (op < 8) do_write(a, $urandom, $urandom_range(1, 4));
      else             do_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_cache_ctrl.md
DATA_CACHE_CTRL -- requirements
Module: data_cache_ctrl

Interface
REQ-001 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL provide port rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL provide port cpu_read  input  1  MEM-stage load request.
REQ-004 SHALL provide port cpu_write  input  1  MEM-stage store request.
REQ-005 SHALL provide port cpu_addr  input  32  byte address, word-aligned; index = cpu_addr[5:2], tag = cpu_addr[31:6].
REQ-006 SHALL provide port cpu_wdata  input  32  store data.
REQ-007 SHALL provide port cpu_rdata  output  32  load data, valid when cpu_read=1 and cache_stall=0.
REQ-008 SHALL provide port cache_stall  output  1  pipeline freeze request, consumed by the hazard unit as its cache-stall input.
REQ-009 SHALL provide port mem_req  output  1  memory transaction request.
REQ-010 SHALL provide port mem_we  output  1  1 = memory write, 0 = memory read.
REQ-011 SHALL provide port mem_addr  output  32  memory word address (byte address).
REQ-012 SHALL provide port mem_wdata  output  32  memory write data.
REQ-013 SHALL provide port mem_ready  input  1  one-cycle completion pulse from memory.
REQ-014 SHALL provide port mem_rdata  input  32  memory read data, valid in the cycle mem_ready=1.

Function
REQ-015 SHALL be direct-mapped, 16 lines, one 32-bit word per line, each line holding 1 valid bit, 26-bit tag, and 32-bit data.
REQ-016 SHALL define hit = valid[index] & (tag[index] == cpu_addr[31:6]).
REQ-017 SHALL be write-through and no-write-allocate.
REQ-018 SHALL implement FSM states IDLE, FETCH, WRITE, WDONE.
REQ-019 SHALL treat cpu_read=1 with cpu_write=1 as a write; cpu_rdata is don't-care in that case.
REQ-020 IDLE: with no request, stall=0 and remain in IDLE.
REQ-021 IDLE: on a read hit, drive cpu_rdata combinationally from the line, stall=0, and remain in IDLE; zero-cycle hit latency.
REQ-022 IDLE: on a read miss, assert cache_stall combinationally in the same cycle, latch cpu_addr into mem_addr, and go to FETCH.
REQ-023 IDLE: on a write, assert cache_stall combinationally, latch cpu_addr into mem_addr and cpu_wdata into mem_wdata, and go to WRITE.
REQ-024 FETCH: drive mem_req=1, mem_we=0, and stall=1.
REQ-025 FETCH: on mem_ready, set valid=1, load tag and mem_rdata into the indexed line (overwriting any previous occupant), and go to IDLE.
REQ-026 After a FETCH completes, the held read SHALL hit in IDLE on the next cycle; read-miss latency = memory latency + 1 cycle.
REQ-027 WRITE: drive mem_req=1, mem_we=1, and stall=1.
REQ-028 WRITE: on mem_ready, update the line's data only if the line was a hit for the latched address (no valid/tag change on a miss), then go to WDONE.
REQ-029 WDONE: drive stall=0, mem_req=0, ignore CPU inputs, and go to IDLE; this is the store's completion cycle.
REQ-030 SHALL register mem_req and mem_we and hold mem_addr and mem_wdata stable for the full duration of mem_req=1.
REQ-031 SHALL deassert mem_req in the cycle after mem_ready.
REQ-032 SHALL ignore mem_ready whenever mem_req=0.
REQ-033 SHALL ignore CPU input changes while in FETCH or WRITE.
REQ-034 Back-to-back requests: a request presented in the first IDLE cycle after FETCH or WDONE SHALL be serviced normally.

Reset
REQ-035 On rst_n=0, asynchronously and regardless of state: state=IDLE, all valid bits=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0; tags and data need not reset.
REQ-036 A reset during FETCH or WRITE SHALL abandon the transaction with no line update; memory-side recovery is not this block's concern.
REQ-037 After reset release with no request, cache_stall SHALL be 0 and mem_req SHALL be 0.

Verification
REQ-038 Cold read: reset; cpu_read, addr 0x0000_0040; mem_ready 3 cycles later with rdata 0xDEAD_BEEF -> stall=1 for 4 cycles, mem_addr=0x40, then cpu_rdata=0xDEAD_BEEF with stall=0.
REQ-039 Hit: repeat the read of 0x40 -> stall=0 in the same cycle, cpu_rdata=0xDEAD_BEEF, mem_req stays 0.
REQ-040 Write hit: cpu_write 0x40, data 0x1234_5678, mem_ready after 2 cycles -> mem_we=1, mem_wdata=0x1234_5678; WDONE has stall=0; a subsequent read of 0x40 hits with 0x1234_5678.
REQ-041 Conflict: read 0x0000_0080 (same index as 0x40, tag differs) -> miss refill; then a read of 0x40 misses again.
REQ-042 Write miss: write 0x0000_0100 -> memory write occurs, no allocation; a later read of 0x100 misses.
REQ-043 Reset mid-FETCH: assert rst_n=0 while mem_req=1 -> mem_req=0 immediately; after release, a read of the same address misses.
